// File: rtl/uart_tx.sv
// uart_tx: async serial transmitter, 16 clk per bit, valid/ready input.
// Frame: start, DATA_BITS LSB first, [parity], STOP_BITS stop bits.
//
// Ports:
//   clk        16x bitrate clock
//   rst        synchronous active-high reset
//   data       word to send, latched on handshake
//   data_valid upstream offers data
//   data_ready block accepts a word this cycle (registered)
//   tx         serial line, idle high (registered)
//   busy       frame in progress (registered)
//
// Optional: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (even parity, or odd when PARITY_ODD=1).
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       TWO_STOP = (STOP_BITS == 2);
  localparam logic [3:0] TICK_END = 4'hF;
  localparam logic [3:0] TICK_PRE = 4'hE;

  state_t               state_q, state_n;
  logic [3:0]           tick_q, tick_n;
  logic [3:0]           bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 stop_q, stop_n;
  logic                 tx_q, tx_n;
  logic                 rdy_q, rdy_n;
  logic                 busy_q, busy_n;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic par_q, par_n;
`endif

  logic accept;
  logic bit_end;
  logic last_stop;

  assign accept    = data_valid && rdy_q;
  assign bit_end   = (tick_q == TICK_END);
  assign last_stop = !TWO_STOP || stop_q;

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q + 4'd1;
    bit_n   = bit_q;
    shift_n = shift_q;
    stop_n  = stop_q;
    tx_n    = tx_q;
    rdy_n   = 1'b0;
    busy_n  = busy_q;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        tick_n = 4'd0;
        tx_n   = 1'b1;
        rdy_n  = 1'b1;
        busy_n = 1'b0;
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          bit_n   = 4'd0;
          tx_n    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
            tx_n    = par_q;
`else
            state_n = S_STOP;
            stop_n  = 1'b0;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n = bit_q + 4'd1;
            tx_n  = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          stop_n  = 1'b0;
          tx_n    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        // ready is registered, so raise it one cycle early to
        // have it high during the final stop cycle
        if (last_stop && tick_q == TICK_PRE) begin
          rdy_n = 1'b1;
        end
        if (bit_end) begin
          if (!last_stop) begin
            stop_n = 1'b1;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
            rdy_n   = 1'b1;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        rdy_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase

    // accept wins over the stop->idle move, giving gapless frames
    if (accept) begin
      state_n = S_START;
      tick_n  = 4'd0;
      bit_n   = 4'd0;
      stop_n  = 1'b0;
      shift_n = data;
      tx_n    = 1'b0;
      rdy_n   = 1'b0;
      busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_n   = (^data) ^ ODD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= 4'd0;
      bit_q   <= 4'd0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      stop_q  <= stop_n;
      tx_q    <= tx_n;
      rdy_q   <= rdy_n;
      busy_q  <= busy_n;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_n;
    end
  end
`endif

  assign tx         = tx_q;
  assign data_ready = rdy_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the TX-side counterpart of the UART receive path. Accepts parallel words via a valid/ready handshake and serialises each as an async frame on tx: start bit, data bits LSB first, optional parity, stop bit(s). Runs on the same 16x-bitrate clock as the receiver, so each bit is held for exactly 16 clk cycles. No internal buffering beyond one shift register; upstream holds data until accepted.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9)
STOP_BITS, 1, number of stop bits (1 or 2)
PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN defined: 0 = even, 1 = odd; ignored otherwise

Ports:
clk  input  1  clock at 16x nominal bitrate
rst  input  1  reset
data  input  DATA_BITS  word to transmit; sampled only on handshake
data_valid  input  1  upstream has a word on data
data_ready  output  1  block can accept a word this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress (any state other than IDLE)

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: tx=1, data_ready=1, busy=0, state=IDLE, tick counter=0, bit index=0, shift register=0.
- All outputs registered; no combinational input->output paths.
- Handshake: word accepted on a clk edge where data_valid && data_ready. data latched into shift register at that edge; later changes to data have no effect. data_valid with data_ready=0 is ignored; upstream must hold it.
- data_ready high in IDLE and during the final clk cycle of the last stop bit; low otherwise.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
- IDLE: tx=1, busy=0. On accept: next cycle state=START, tx=0, busy=1.
- Tick counter: 4 bits, cleared on entering each bit, increments every cycle; bit ends when it reaches 15 (wraps to 0). Every bit, start and stop included, is exactly 16 cycles.
- START: tx=0 for 16 cycles -> DATA.
- DATA: tx=shift[0]; shift right at each bit end; bit index counts 0..DATA_BITS-1; after bit DATA_BITS-1 -> PARITY (if enabled) else STOP.
- STOP: tx=1 for 16*STOP_BITS cycles. In the final cycle data_ready=1. If accepted then: next cycle START (tx=0), no idle gap. Otherwise -> IDLE.
- Latency: tx falls exactly 1 cycle after the accepting edge.
- Frame length without parity: 16*(1+DATA_BITS+STOP_BITS) cycles (160 for 8N1).
- Reset mid-frame: the next cycle has tx=1, IDLE, data_ready=1; the partial frame is abandoned. No glitch on tx beyond the truncated bit.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state inserted between DATA and STOP, 16 cycles. tx = XOR of latched data bits, inverted when PARITY_ODD=1. Parity computed from the word latched at accept. Frame = 16*(2+DATA_BITS+STOP_BITS).
- Undefined: no PARITY state, no parity logic; PARITY_ODD unused.

Test Plan:
- Reset release, data_valid=0 for 100 cycles -> tx=1, data_ready=1, busy=0 throughout.
- Send 0xA5 (8N1) -> tx low 16 cycles starting 1 cycle after accept; then bits 1,0,1,0,0,1,0,1 at 16 cycles each; then high 16 cycles; busy high exactly 160 cycles; data_ready low from accept+1 until the final stop cycle.
- Back-to-back 0x00 then 0xFF with data_valid held high -> second accept in the last stop cycle of frame 1; frame 2 start bit begins the next cycle; total 320 cycles with no idle gap.
- data changed to 0x3C one cycle after accepting 0x81 -> frame still carries 0x81; data_valid asserted mid-frame is not accepted until the stop bit.
- rst pulsed at cycle 70 of a 0x55 frame -> tx=1, data_ready=1, busy=0 the next cycle; new 0x0F frame afterwards is correct.
- UART_TX_PARITY_EN, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 176 cycles; PARITY_ODD=1 -> parity bit 0; STOP_BITS=2 -> stop high 32 cycles.
